mm_seq_ctrl: RTL
================

Name: mm_seq_ctrl

Overview:
- Parametrised sequencer for the vector × matrix engine.
- Walks the node / output-chunk / input-chunk loop nest and issues read addresses to the input, weight, bias and accumulate buffers.
- Carries per-issue tags through a fixed-latency pipeline and emits the output-buffer write strobe, accumulator clear, bias/acc/relu selects and a done pulse.
- Adds issue backpressure, zero-dimension handling and busy status.

Parameters:
- IN_AW, 11, input buffer address width
- W_AW, 13, weight buffer address width
- OUT_AW, 11, output buffer address width
- B_AW, 9, bias buffer address width
- DIM_W, 8, width of Ci/Co fields
- N_W, 16, width of node count
- PIPE_LAT, 11, cycles from address issue to datapath result-valid (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle start pulse
- cfg_in_base  in  IN_AW  input start address
- cfg_w_base  in  W_AW  weight start address
- cfg_out_base  in  OUT_AW  output start address (acc read and write)
- cfg_b_base  in  B_AW  bias start address
- cfg_ci  in  DIM_W  input chunks per feature
- cfg_co  in  DIM_W  output chunks per feature
- cfg_n  in  N_W  node count
- cfg_bias / cfg_acc / cfg_relu  in  1 each  mode enables
- hold  in  1  downstream backpressure; blocks new issue
- in_addr / in_addr_valid  out  IN_AW / 1
- w_addr / w_addr_valid  out  W_AW / 1
- b_addr / b_addr_valid  out  B_AW / 1
- acc_addr / acc_addr_valid  out  OUT_AW / 1
- dp_clear  out  1  datapath drops partial sum (first ci of a chunk)
- dp_add_bias / dp_add_acc  out  1  select bias / acc add on last ci
- dp_relu  out  1  registered cfg_relu
- out_addr / out_we  out  OUT_AW / 1  output write
- busy  out  1
- done  out  1  one-cycle pulse
- perf_cycles / perf_hold  out  32 / 32  performance counters (feature-gated)

Behaviour:
- Reset (rst=1, async): every output 0, FSM in IDLE, tag pipe empty, counters cleared.
- Start handling:
  - start is sampled only in IDLE; a start in any other state is ignored.
  - All cfg_* are captured on start and held for the whole run.
- FSM states:
  - IDLE → ISSUE on start when all of cfg_ci, cfg_co, cfg_n are nonzero; otherwise IDLE → FIN (no issue at all).
  - ISSUE → DRAIN after the final triple is issued.
  - DRAIN → FIN when the tag pipe is empty.
  - FIN → IDLE: done=1 for exactly one cycle.
  - busy=1 in every state except IDLE.
- Loop order: ci innermost, then co, then n. An issue occurs in a cycle in ISSUE with hold=0. With hold=1, no issue occurs, counters and addresses freeze, and all *_valid outputs are 0.
- Addresses, valid on the issue cycle, computed incrementally (no multipliers):
  - in_addr = in_base + n·Ci + ci
  - w_addr = w_base + co·Ci + ci
  - b_addr = b_base + co
  - acc_addr = out_base + n·Co + co
- Valid strobes: b_addr_valid only when cfg_bias=1; acc_addr_valid only when cfg_acc=1.
- Address arithmetic wraps modulo 2^width; there is no overflow flag.
- Tag pipe: PIPE_LAT-deep shift register. Each stage holds {valid, first, last, out_addr}. It always advances and is never stalled by hold. Issue slots blocked by hold insert bubbles.
- At the pipe output, for a valid tag only:
  - dp_clear = first
  - out_we = last; out_addr = tag.out_addr
  - dp_add_bias = last & cfg_bias; dp_add_acc = last & cfg_acc
- Ci=1: first and last are both set on the same tag.
- Reset mid-run: everything aborts immediately; no done pulse.
- Total out_we pulses per run = N·Co. Write order is strictly increasing out_addr modulo wrap.

Optional Feature:
- Macro: MM_PERF_CNT_EN.
- Defined: perf_cycles counts cycles with busy=1; perf_hold counts cycles in ISSUE with hold=1. Both clear on accepted start and saturate at 2^32−1.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Decomposition:
- Package mm_pkg:
  - mm_tag_t struct {valid, first, last, out_addr}
  - FSM state enum {IDLE, ISSUE, DRAIN, FIN}
  - default width localparams
- Sub-module: mm_tag_pipe, the parametrised PIPE_LAT-stage tag shift register.

Test Plan:
- Ci=2, Co=2, N=2, bases 0, hold=0 → in_addr sequence 0,1,0,1,2,3,2,3; w_addr 0,1,2,3 repeated; out_we 4 times at 0,1,2,3, first write PIPE_LAT cycles after the 2nd issue; done 1 cycle after the last out_we.
- Same config with cfg_bias=1, cfg_acc=1, b_base=5, out_base=100 → b_addr 5,5,6,6,…; acc_addr 100,100,101,101,…; dp_add_bias and dp_add_acc high exactly on the 4 out_we cycles.
- hold asserted for 3 cycles mid-ISSUE → no valid strobes during the hold; address sequence resumes unchanged; out_we count is still 4; done is delayed by 3 cycles.
- cfg_n=0 → no *_valid strobes; done pulses 2 cycles after start; busy high only between.
- Second start while busy → ignored; the run completes with the original config.
- rst pulsed mid-ISSUE → all outputs 0 immediately; no done; a new start runs cleanly.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and default widths for the vector x matrix sequencer (mm_seq_ctrl).
package mm_pkg;

  localparam int unsigned DefInAw    = 11;
  localparam int unsigned DefWAw     = 13;
  localparam int unsigned DefOutAw   = 11;
  localparam int unsigned DefBAw     = 9;
  localparam int unsigned DefDimW    = 8;
  localparam int unsigned DefNW      = 16;
  localparam int unsigned DefPipeLat = 11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFin
  } mm_state_e;

  // Default-width tag; the top re-declares it with its own OUT_AW.
  typedef struct packed {
    logic                valid;
    logic                first;
    logic                last;
    logic [DefOutAw-1:0] out_addr;
  } mm_tag_t;

endpackage

// File: rtl/mm_tag_pipe.sv
// Fixed-latency tag shift register: always advances, blocked issue slots enter as invalid tags.
module mm_tag_pipe
  import mm_pkg::*;
#(
  parameter int unsigned PIPE_LAT = DefPipeLat,
  parameter type         tag_t    = mm_tag_t
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic tail_busy
);

  tag_t [PIPE_LAT-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[PIPE_LAT-2:0], tag_in};
    end
  end

  assign tag_out = stage_q[PIPE_LAT-1];

  // Tags still two or more stages away from the output.
  always_comb begin
    tail_busy = 1'b0;
    for (int i = 0; i + 2 < int'(PIPE_LAT); i++) begin
      tail_busy = tail_busy | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Vector x matrix sequencer: walks n/co/ci, issues buffer reads, retires tags into write strobes.
// Optional perf counters are built only when MM_PERF_CNT_EN is defined.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned IN_AW    = DefInAw,
  parameter int unsigned W_AW     = DefWAw,
  parameter int unsigned OUT_AW   = DefOutAw,
  parameter int unsigned B_AW     = DefBAw,
  parameter int unsigned DIM_W    = DefDimW,
  parameter int unsigned N_W      = DefNW,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_AW-1:0]  cfg_in_base,
  input  logic [W_AW-1:0]   cfg_w_base,
  input  logic [OUT_AW-1:0] cfg_out_base,
  input  logic [B_AW-1:0]   cfg_b_base,
  input  logic [DIM_W-1:0]  cfg_ci,
  input  logic [DIM_W-1:0]  cfg_co,
  input  logic [N_W-1:0]    cfg_n,
  input  logic              cfg_bias,
  input  logic              cfg_acc,
  input  logic              cfg_relu,
  input  logic              hold,
  output logic [IN_AW-1:0]  in_addr,
  output logic              in_addr_valid,
  output logic [W_AW-1:0]   w_addr,
  output logic              w_addr_valid,
  output logic [B_AW-1:0]   b_addr,
  output logic              b_addr_valid,
  output logic [OUT_AW-1:0] acc_addr,
  output logic              acc_addr_valid,
  output logic              dp_clear,
  output logic              dp_add_bias,
  output logic              dp_add_acc,
  output logic              dp_relu,
  output logic [OUT_AW-1:0] out_addr,
  output logic              out_we,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_hold
);

  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic [OUT_AW-1:0] out_addr;
  } tag_t;

  mm_state_e         state_q, state_d;
  logic [DIM_W-1:0]  ci_q, co_q, ci_cnt_q, co_cnt_q;
  logic [N_W-1:0]    n_q, n_cnt_q;
  logic [IN_AW-1:0]  in_addr_q, in_row_q;
  logic [W_AW-1:0]   w_base_q, w_addr_q;
  logic [B_AW-1:0]   b_base_q, b_addr_q;
  logic [OUT_AW-1:0] acc_addr_q;
  logic              bias_q, acc_q, relu_q, done_q;
  logic              start_acc, issue, ci_last, co_last, n_last, final_issue, tail_busy;
  tag_t              tag_in, tag_out;

  assign start_acc   = (state_q == StIdle) & start;
  assign issue       = (state_q == StIssue) & ~hold;
  assign ci_last     = (ci_cnt_q == ci_q - DIM_W'(1));
  assign co_last     = (co_cnt_q == co_q - DIM_W'(1));
  assign n_last      = (n_cnt_q == n_q - N_W'(1));
  assign final_issue = issue & ci_last & co_last & n_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = ((|cfg_ci) && (|cfg_co) && (|cfg_n)) ? StIssue : StFin;
        end
      end
      StIssue: if (final_issue) state_d = StDrain;
      // Leave once the last tag is one stage from the output: its write lands in FIN
      // and the registered done follows it by exactly one cycle.
      StDrain: if (!tail_busy) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StFin);
    end
  end

  // Addresses advance incrementally; each loop wrap rewinds to a saved row/base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ci_q       <= '0;
      co_q       <= '0;
      n_q        <= '0;
      ci_cnt_q   <= '0;
      co_cnt_q   <= '0;
      n_cnt_q    <= '0;
      in_addr_q  <= '0;
      in_row_q   <= '0;
      w_base_q   <= '0;
      w_addr_q   <= '0;
      b_base_q   <= '0;
      b_addr_q   <= '0;
      acc_addr_q <= '0;
      bias_q     <= 1'b0;
      acc_q      <= 1'b0;
      relu_q     <= 1'b0;
    end else if (start_acc) begin
      ci_q       <= cfg_ci;
      co_q       <= cfg_co;
      n_q        <= cfg_n;
      ci_cnt_q   <= '0;
      co_cnt_q   <= '0;
      n_cnt_q    <= '0;
      in_addr_q  <= cfg_in_base;
      in_row_q   <= cfg_in_base;
      w_base_q   <= cfg_w_base;
      w_addr_q   <= cfg_w_base;
      b_base_q   <= cfg_b_base;
      b_addr_q   <= cfg_b_base;
      acc_addr_q <= cfg_out_base;
      bias_q     <= cfg_bias;
      acc_q      <= cfg_acc;
      relu_q     <= cfg_relu;
    end else if (issue) begin
      if (!ci_last) begin
        ci_cnt_q  <= ci_cnt_q + DIM_W'(1);
        in_addr_q <= in_addr_q + IN_AW'(1);
        w_addr_q  <= w_addr_q + W_AW'(1);
      end else begin
        ci_cnt_q   <= '0;
        acc_addr_q <= acc_addr_q + OUT_AW'(1);
        if (!co_last) begin
          co_cnt_q  <= co_cnt_q + DIM_W'(1);
          in_addr_q <= in_row_q;
          w_addr_q  <= w_addr_q + W_AW'(1);
          b_addr_q  <= b_addr_q + B_AW'(1);
        end else begin
          co_cnt_q  <= '0;
          n_cnt_q   <= n_cnt_q + N_W'(1);
          in_addr_q <= in_addr_q + IN_AW'(1);
          in_row_q  <= in_addr_q + IN_AW'(1);
          w_addr_q  <= w_base_q;
          b_addr_q  <= b_base_q;
        end
      end
    end
  end

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = issue;
    tag_in.first    = (ci_cnt_q == '0);
    tag_in.last     = ci_last;
    tag_in.out_addr = acc_addr_q;
  end

  mm_tag_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .tag_t    (tag_t)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .tail_busy (tail_busy)
  );

  assign in_addr        = in_addr_q;
  assign w_addr         = w_addr_q;
  assign b_addr         = b_addr_q;
  assign acc_addr       = acc_addr_q;
  assign in_addr_valid  = issue;
  assign w_addr_valid   = issue;
  assign b_addr_valid   = issue & bias_q;
  assign acc_addr_valid = issue & acc_q;

  assign out_we      = tag_out.valid & tag_out.last;
  assign out_addr    = tag_out.valid ? tag_out.out_addr : '0;
  assign dp_clear    = tag_out.valid & tag_out.first;
  assign dp_add_bias = out_we & bias_q;
  assign dp_add_acc  = out_we & acc_q;
  assign dp_relu     = relu_q;

  assign busy = (state_q != StIdle);
  assign done = done_q;

`ifdef MM_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_hold_q   <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_hold_q   <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == StIssue) && hold && (perf_hold_q != '1)) begin
        perf_hold_q <= perf_hold_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_hold   = perf_hold_q;
`else
  assign perf_cycles = '0;
  assign perf_hold   = '0;
`endif

endmodule
